// File: rtl/vend_pkg.sv
// Shared types and constants for the dispense sequencer.
// Holds the FSM state enum, the coin values and a coin-pick helper.
package vend_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOTOR,
    S_GAP,
    S_COIN,
    S_WAIT_ACK,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [3:0] COIN_HI = 4'd2;
  localparam logic [3:0] COIN_LO = 4'd1;

  function automatic logic [3:0] coin_val(
    input logic [3:0] rem
  );
    return (rem >= COIN_HI) ? COIN_HI : COIN_LO;
  endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter shared by all timed phases.
// Ports: clk, rst_n, load_i/val_i (load), dec_i (count down), last_o (count is 0).
module vend_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/vend_dispense_seq.sv
// Vending dispense sequencer: motor run, gap, then coin-by-coin change.
// In: clk, rst (async low), vend_req/prod/bal, coin_ack, err_clr. Out: busy, motor_en/sel, coin2/1, done, err.
module vend_dispense_seq #(
  parameter int MOTOR_CYC = 4,
  parameter int COIN_CYC  = 2,
  parameter int GAP_CYC   = 1,
  parameter int ACK_TO    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vend_req,
  input  logic [1:0] prod,
  input  logic [3:0] bal,
  input  logic       coin_ack,
  input  logic       err_clr,
  output logic       busy,
  output logic       motor_en,
  output logic [1:0] motor_sel,
  output logic       coin2,
  output logic       coin1,
  output logic       done,
  output logic       err
);

  import vend_pkg::*;

  localparam int M1 = (MOTOR_CYC > ACK_TO) ? MOTOR_CYC : ACK_TO;
  localparam int M2 = (M1 > COIN_CYC) ? M1 : COIN_CYC;
  localparam int M3 = (M2 > GAP_CYC) ? M2 : GAP_CYC;
  localparam int TW = (M3 < 2) ? 1 : $clog2(M3);

  localparam logic [TW-1:0] MOT_LD = TW'(MOTOR_CYC - 1);
  localparam logic [TW-1:0] GAP_LD = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0] CN_LD  = TW'(COIN_CYC - 1);
  localparam logic [TW-1:0] ACK_LD = TW'(ACK_TO - 1);

  state_e    state_q, state_d;
  logic [3:0] rem_q, rem_d;
  logic [1:0] prod_q, prod_d;

  logic          t_load;
  logic [TW-1:0] t_val;
  logic          t_dec;
  logic          t_last;

  logic [3:0] cv;
  logic [3:0] rem_sub;

  logic       busy_q, motor_q, c2_q, c1_q, done_q, err_q;
  logic [1:0] sel_q;

  // Saturating subtract keeps the balance from wrapping.
  assign cv      = coin_val(rem_q);
  assign rem_sub = (rem_q >= cv) ? (rem_q - cv) : 4'd0;

  vend_timer #(
    .W(TW)
  ) u_tmr (
    .clk   (clk),
    .rst_n (rst),
    .load_i(t_load),
    .val_i (t_val),
    .dec_i (t_dec),
    .last_o(t_last)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    prod_d  = prod_q;
    t_load  = 1'b0;
    t_val   = '0;
    t_dec   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (vend_req) begin
          prod_d = prod;
          rem_d  = bal;
          if (prod != 2'd0) begin
            state_d = S_MOTOR;
            t_load  = 1'b1;
            t_val   = MOT_LD;
          end else if (bal != 4'd0) begin
            state_d = S_COIN;
            t_load  = 1'b1;
            t_val   = CN_LD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_MOTOR: begin
        t_dec = 1'b1;
        if (t_last) begin
          if (rem_q != 4'd0) begin
            state_d = S_GAP;
            t_load  = 1'b1;
            t_val   = GAP_LD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_GAP: begin
        t_dec = 1'b1;
        if (t_last) begin
          state_d = S_COIN;
          t_load  = 1'b1;
          t_val   = CN_LD;
        end
      end
      S_COIN: begin
        t_dec = 1'b1;
        if (t_last) begin
          state_d = S_WAIT_ACK;
          t_load  = 1'b1;
          t_val   = ACK_LD;
        end
      end
      S_WAIT_ACK: begin
        t_dec = 1'b1;
        // An ack in the final timeout cycle still counts.
        if (coin_ack) begin
          rem_d = rem_sub;
          if (rem_sub != 4'd0) begin
            state_d = S_COIN;
            t_load  = 1'b1;
            t_val   = CN_LD;
          end else begin
            state_d = S_DONE;
          end
        end else if (t_last) begin
          state_d = S_ERR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        if (err_clr) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rem_q   <= 4'd0;
      prod_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      prod_q  <= prod_d;
    end
  end

  // Outputs are registered decodes of the current state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q  <= 1'b0;
      motor_q <= 1'b0;
      sel_q   <= 2'd0;
      c2_q    <= 1'b0;
      c1_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      busy_q  <= (state_q != S_IDLE);
      motor_q <= (state_q == S_MOTOR);
      sel_q   <= (state_q == S_MOTOR) ? prod_q : 2'd0;
      c2_q    <= (state_q == S_COIN) && (rem_q >= COIN_HI);
      c1_q    <= (state_q == S_COIN) && (rem_q < COIN_HI);
      done_q  <= (state_q == S_DONE);
      err_q   <= (state_q == S_ERR);
    end
  end

  assign busy      = busy_q;
  assign motor_en  = motor_q;
  assign motor_sel = sel_q;
  assign coin2     = c2_q;
  assign coin1     = c1_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_vend_dispense_seq.sv
// Bench for vend_dispense_seq: cycle vectors plus multi-cycle sequences.
// Drives on negedge; vectors compare #1 after the sampling posedge.
module tb_vend_dispense_seq;

  logic       clk;
  logic       rst;
  logic       vend_req;
  logic [1:0] prod;
  logic [3:0] bal;
  logic       coin_ack;
  logic       err_clr;
  logic       busy;
  logic       motor_en;
  logic [1:0] motor_sel;
  logic       coin2;
  logic       coin1;
  logic       done;
  logic       err;
  logic [7:0] ov;

  int n_chk;
  int n_fail;

  vend_dispense_seq #(
    .MOTOR_CYC(4),
    .COIN_CYC (2),
    .GAP_CYC  (1),
    .ACK_TO   (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .vend_req (vend_req),
    .prod     (prod),
    .bal      (bal),
    .coin_ack (coin_ack),
    .err_clr  (err_clr),
    .busy     (busy),
    .motor_en (motor_en),
    .motor_sel(motor_sel),
    .coin2    (coin2),
    .coin1    (coin1),
    .done     (done),
    .err      (err)
  );

  assign ov = {busy, motor_en, motor_sel, coin2, coin1, done, err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vr;
    logic [1:0] pr;
    logic [3:0] bl;
    logic       ack;
    logic       clr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (coin1 && coin2) begin
      n_fail++;
      $display("FAIL both_strobes: got 11 expected at most one");
    end
  end

  task automatic wait_drop(output int kind);
    logic p2, p1;
    kind = 0;
    p2 = coin2;
    p1 = coin1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (p2 && !coin2) begin
        kind = 2;
        break;
      end
      if (p1 && !coin1) begin
        kind = 1;
        break;
      end
      p2 = coin2;
      p1 = coin1;
    end
  endtask

  task automatic wait_done(input int lim, output int seen, output int errs);
    seen = 0;
    errs = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (err) errs++;
      if (done) begin
        seen = 1;
        break;
      end
    end
  endtask

  task automatic req(input logic [1:0] p, input logic [3:0] b);
    @(negedge clk);
    vend_req = 1'b1;
    prod     = p;
    bal      = b;
    @(negedge clk);
    vend_req = 1'b0;
    prod     = 2'd0;
    bal      = 4'd0;
  endtask

  int mcnt, selbad, seq, scnt, dcnt, ecnt, kind, seen, errs, bad;
  logic p2, p1;

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst      = 1'b0;
    vend_req = 1'b1;
    prod     = 2'd1;
    bal      = 4'd1;
    coin_ack = 1'b0;
    err_clr  = 1'b0;

    // exp = {busy, motor_en, motor_sel, coin2, coin1, done, err}
    vecs[0]  = '{1'b1, 2'd0, 4'd0,  1'b0, 1'b0, 8'b0000_0000};
    vecs[1]  = '{1'b1, 2'd1, 4'd1,  1'b0, 1'b0, 8'b1000_0010};
    vecs[2]  = '{1'b0, 2'd0, 4'd0,  1'b0, 1'b0, 8'b0000_0000};
    vecs[3]  = '{1'b0, 2'd0, 4'd0,  1'b0, 1'b0, 8'b0000_0000};
    vecs[4]  = '{1'b1, 2'd1, 4'd1,  1'b0, 1'b0, 8'b0000_0000};
    vecs[5]  = '{1'b0, 2'd0, 4'd0,  1'b0, 1'b1, 8'b1101_0000};
    vecs[6]  = '{1'b0, 2'd0, 4'd0,  1'b0, 1'b0, 8'b1101_0000};
    vecs[7]  = '{1'b1, 2'd3, 4'd15, 1'b0, 1'b0, 8'b1101_0000};
    vecs[8]  = '{1'b0, 2'd0, 4'd0,  1'b0, 1'b0, 8'b1101_0000};
    vecs[9]  = '{1'b0, 2'd0, 4'd0,  1'b1, 1'b0, 8'b1000_0000};
    vecs[10] = '{1'b0, 2'd0, 4'd0,  1'b1, 1'b0, 8'b1000_0100};
    vecs[11] = '{1'b0, 2'd0, 4'd0,  1'b0, 1'b0, 8'b1000_0100};
    vecs[12] = '{1'b0, 2'd0, 4'd0,  1'b1, 1'b0, 8'b1000_0000};
    vecs[13] = '{1'b0, 2'd0, 4'd0,  1'b0, 1'b0, 8'b1000_0010};
    vecs[14] = '{1'b0, 2'd0, 4'd0,  1'b0, 1'b0, 8'b0000_0000};

    // reset held with a request present
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'(ov), 32'h0);
    vend_req = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", 32'(ov), 32'h0);

    // null vend, ignored DONE-cycle request, then prod=1 bal=1
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      vend_req = vecs[i].vr;
      prod     = vecs[i].pr;
      bal      = vecs[i].bl;
      coin_ack = vecs[i].ack;
      err_clr  = vecs[i].clr;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), 32'(ov), 32'(vecs[i].exp));
    end
    @(negedge clk);
    vend_req = 1'b0;
    prod     = 2'd0;
    bal      = 4'd0;
    coin_ack = 1'b0;
    err_clr  = 1'b0;

    // prod=2 bal=5, prompt acks
    req(2'd2, 4'd5);
    mcnt = 0; selbad = 0; seq = 0; scnt = 0; dcnt = 0; ecnt = 0;
    p2 = 1'b0; p1 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      coin_ack = 1'b0;
      if (motor_en) begin
        mcnt++;
        if (motor_sel != 2'd2) selbad++;
      end
      if (coin2 || coin1) scnt++;
      if (p2 && !coin2) begin
        seq = seq * 10 + 2;
        coin_ack = 1'b1;
      end
      if (p1 && !coin1) begin
        seq = seq * 10 + 1;
        coin_ack = 1'b1;
      end
      if (done) dcnt++;
      if (err) ecnt++;
      p2 = coin2;
      p1 = coin1;
      @(negedge clk);
    end
    coin_ack = 1'b0;
    chk("p2b5_motor_cycles", 32'(mcnt), 32'd4);
    chk("p2b5_motor_sel", 32'(selbad), 32'd0);
    chk("p2b5_coin_seq", 32'(seq), 32'd221);
    chk("p2b5_strobe_cycles", 32'(scnt), 32'd6);
    chk("p2b5_done_pulses", 32'(dcnt), 32'd1);
    chk("p2b5_no_err", 32'(ecnt), 32'd0);

    // prod=1 bal=3, no ack -> timeout
    req(2'd1, 4'd3);
    wait_drop(kind);
    chk("to_first_coin", 32'(kind), 32'd2);
    repeat (7) @(negedge clk);
    chk("to_err_not_early", 32'(err), 32'd0);
    @(negedge clk);
    chk("to_err_at_8", 32'(ov), 32'b1000_0001);
    repeat (2) @(negedge clk);
    chk("to_err_held", 32'(ov), 32'b1000_0001);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    chk("to_err_cleared", 32'(ov), 32'h0);

    // prod=0 bal=3, ack in the final timeout cycle
    req(2'd0, 4'd3);
    wait_drop(kind);
    chk("last_first_coin", 32'(kind), 32'd2);
    repeat (6) @(negedge clk);
    chk("last_no_err_yet", 32'(err), 32'd0);
    coin_ack = 1'b1;
    @(negedge clk);
    coin_ack = 1'b0;
    chk("last_ack_no_err", 32'(err), 32'd0);
    wait_drop(kind);
    chk("last_second_coin1", 32'(kind), 32'd1);
    coin_ack = 1'b1;
    @(negedge clk);
    coin_ack = 1'b0;
    wait_done(10, seen, errs);
    chk("last_done_seen", 32'(seen), 32'd1);
    chk("last_no_err", 32'(errs), 32'd0);

    // prod=0 bal=4, reset during second coin
    req(2'd0, 4'd4);
    wait_drop(kind);
    chk("rst_first_coin", 32'(kind), 32'd2);
    coin_ack = 1'b1;
    @(negedge clk);
    coin_ack = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (coin2) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_second_coin_seen", 32'(seen), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_async_clear", 32'(ov), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ov != 8'h0) bad++;
    end
    chk("rst_no_activity", 32'(bad), 32'd0);
    req(2'd0, 4'd0);
    wait_done(6, seen, errs);
    chk("rst_next_req_done", 32'(seen), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_dispense_seq.md
VEND_DISPENSE_SEQ -- requirements
Module: vend_dispense_seq

Interface
REQ-001 SHALL have parameter MOTOR_CYC, default 4: number of cycles motor_en is held high per dispense.
REQ-002 SHALL have parameter COIN_CYC, default 2: number of cycles a coin-eject strobe is held high.
REQ-003 SHALL have parameter GAP_CYC, default 1: number of idle cycles between the motor phase and the first coin eject.
REQ-004 SHALL have parameter ACK_TO, default 8: maximum cycles spent in WAIT_ACK before the error state is entered.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port vend_req, input, 1 bit: one-cycle request from the vending core; prod and bal are valid with it.
REQ-008 SHALL have port prod, input, 2 bits: product code; 0 means no product.
REQ-009 SHALL have port bal, input, 4 bits: change owed, in units (0..15).
REQ-010 SHALL have port coin_ack, input, 1 bit: ejector confirms that one coin has dropped.
REQ-011 SHALL have port err_clr, input, 1 bit: leaves the error state.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port motor_en, output, 1 bit: drives the dispense motor.
REQ-014 SHALL have port motor_sel, output, 2 bits: latched product code; 0 whenever motor_en is 0.
REQ-015 SHALL have port coin2, output, 1 bit: strobe to eject a 2-unit coin.
REQ-016 SHALL have port coin1, output, 1 bit: strobe to eject a 1-unit coin.
REQ-017 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-018 SHALL have port err, output, 1 bit: high while in the ERR state.

Function
REQ-019 SHALL have states IDLE, MOTOR, GAP, COIN, WAIT_ACK, DONE and ERR.
REQ-020 SHALL, in IDLE, on the edge where vend_req=1, latch prod and bal, then go to MOTOR if prod≠0, else COIN if bal≠0, else DONE.
REQ-021 SHALL ignore vend_req in every state other than IDLE; there is no queueing.
REQ-022 SHALL hold motor_en=1 for exactly MOTOR_CYC cycles in MOTOR, then go to GAP if remaining balance ≠0, else DONE.
REQ-023 SHALL spend GAP_CYC cycles in GAP with all strobes low, then go to COIN.
REQ-024 SHALL, in COIN, assert coin2 if remaining ≥2, else coin1, for COIN_CYC cycles; never both in the same cycle.
REQ-025 SHALL, in WAIT_ACK, on coin_ack=1 subtract the coin value (2 or 1) from remaining, then go to COIN if the result is ≠0, else DONE.
REQ-026 SHALL ignore coin_ack outside WAIT_ACK.
REQ-027 SHALL go to ERR if WAIT_ACK has lasted ACK_TO cycles without coin_ack; coin_ack in the final cycle wins.
REQ-028 SHALL pulse done for one cycle in DONE, then return to IDLE; a vend_req in the DONE cycle is ignored.
REQ-029 SHALL, in ERR, drive all strobes and motor_en low, hold busy=1 and err=1, and return to IDLE on err_clr=1; err_clr is ignored elsewhere.
REQ-030 SHALL hold the remaining-balance register at 4 bits, unsigned, and never let it underflow.
REQ-031 SHALL drive all outputs from registers; no input may reach an output combinationally.

Reset
REQ-032 SHALL, while rst=0, immediately force state=IDLE, remaining=0, latched product=0, timers=0, and all outputs to 0.
REQ-033 SHALL abort any transaction in progress when reset is asserted mid-operation, and SHALL NOT emit done after release.
REQ-034 SHALL leave IDLE no earlier than the first rising edge after rst returns to 1.

Structure
REQ-035 SHALL place the state enum and the coin-value constants COIN_HI=2 and COIN_LO=1 in the shared package vend_pkg.
REQ-036 SHALL implement the MOTOR, GAP, COIN and WAIT_ACK phase counters with one reusable loadable down-counter sub-module, vend_timer.

Verification
REQ-037 SHALL cover: prod=2, bal=5, coin_ack 1 cycle after each strobe -> motor_en high 4 cycles with motor_sel=2, then coin2, coin2, coin1, then one done pulse.
REQ-038 SHALL cover: prod=0, bal=0 -> done exactly 2 cycles after vend_req, with motor_en and both strobes never high.
REQ-039 SHALL cover: prod=1, bal=3, no coin_ack -> err=1 exactly 8 cycles after WAIT_ACK is entered; err_clr then returns busy to 0.
REQ-040 SHALL cover: vend_req re-pulsed during MOTOR with bal=15 -> ignored; the first transaction completes with the original latched values.
REQ-041 SHALL cover: rst=0 during the second coin eject -> all outputs 0 in the same cycle, no done pulse, and the next vend_req is accepted normally.
REQ-042 SHALL cover: coin_ack asserted in the last timeout cycle -> no ERR, and the count decrements normally.
